// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants, FSM state type and range check for mem_access_ctrl
package mem_ctrl_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int LEN_W     = 4;
    localparam int MEM_DEPTH = 16384;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        RSP
    } state_t;

    // Widened by one bit so MEM_DEPTH itself is representable in the compare.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < (ADDR_W+1)'(MEM_DEPTH);
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store/burst-read initiator for 16Ki x 16 main memory
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] nxt_addr;
    logic [LEN_W-1:0]  beat;
    logic [LEN_W-1:0]  len;
    logic              accept;
    logic              rsp_hs;
    logic              req_bad;
    logic              nxt_bad;

    // Write-enable and handshake flags are pure decodes of state, so an
    // asynchronous reset drops them in the same instant.
    assign req_ready        = (state == IDLE);
    assign busy             = (state != IDLE);
    assign rsp_valid        = (state == RSP);
    assign mem_write_enable = (state == WR);

    assign accept   = req_valid & req_ready;
    assign rsp_hs   = rsp_valid & rsp_ready;
    assign nxt_addr = cur + 1'b1;
    assign req_bad  = !addr_ok(req_addr) || (req_write && (req_len != '0));
    assign nxt_bad  = !addr_ok(nxt_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_next = RSP;
                    end else if (req_write) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_next = RD_DATA;
            RD_DATA: state_next = RSP;
            WR:      state_next = RSP;
            RSP: begin
                if (rsp_hs) begin
                    if (rsp_last) begin
                        state_next = IDLE;
                    end else if (nxt_bad) begin
                        state_next = RSP;
                    end else begin
                        state_next = RD_ADDR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response fields are loaded on entry to RSP and otherwise held, which
    // keeps them stable while the consumer applies backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur         <= '0;
            beat        <= '0;
            len         <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_last    <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur  <= req_addr;
                        beat <= '0;
                        len  <= req_len;
                        if (req_bad) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                        end else begin
                            mem_addr <= req_addr;
                            if (req_write) begin
                                mem_data_in <= req_wdata;
                            end
                        end
                    end
                end
                RD_DATA: begin
                    rsp_rdata <= mem_data_out;
                    rsp_err   <= 1'b0;
                    rsp_last  <= (beat == len);
                end
                WR: begin
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    rsp_last  <= 1'b1;
                end
                RSP: begin
                    if (rsp_hs && !rsp_last) begin
                        cur  <= nxt_addr;
                        beat <= beat + 1'b1;
                        if (nxt_bad) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            rsp_last  <= 1'b1;
                        end else begin
                            mem_addr <= nxt_addr;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
